ecc_scrub_ctrl: RTL and testbench

- Sequencer for the team's 32/39 SECDED unit `hamming_ecc_unit`. Sits between a single CPU data port and a single-port synchronous 39-bit memory.
- On CPU writes it encodes the data. On CPU reads it checks and corrects the data, and writes corrected codewords back to memory.
- A background scrubber walks the whole array, repairing single-bit errors and logging uncorrectable ones. CPU traffic has strict priority over scrub traffic.

---
 rtl/ecc_ctrl_pkg.sv | 39 +++
 rtl/ecc_scrub_ctrl_if.sv | 25 ++
 rtl/hamming_ecc_unit.sv | 41 ++++
 rtl/ecc_scrub_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_ctrl_pkg.sv
// Shared types, constants and Hamming helpers for the ECC scrub controller.
package ecc_ctrl_pkg;

  localparam int CODE_W = 39;
  localparam int DATA_W = 32;
  localparam int PAR_W  = 6;

  typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD, ST_CHK, ST_WB} state_e;
  typedef enum logic {SRC_CPU, SRC_SCRUB} src_e;

  localparam logic [1:0] RSP_CLEAN  = 2'b00;
  localparam logic [1:0] RSP_CORR   = 2'b01;
  localparam logic [1:0] RSP_UNCORR = 2'b10;

  // Hamming positions 1..38: powers of two hold check bits, the rest hold
  // data bits 0..31 in ascending order.
  function automatic logic is_data_pos(input logic [5:0] pos);
    return (pos >= 6'd3) && ((pos & (pos - 6'd1)) != 6'd0);
  endfunction

  // Check bit i covers every data position whose index has bit i set.
  function automatic logic [PAR_W-1:0] calc_par(input logic [DATA_W-1:0] d);
    logic [PAR_W-1:0] par;
    logic [5:0]       pos;
    int               k;
    par = '0;
    k   = 0;
    for (int p = 3; p <= 38; p++) begin
      pos = 6'(p);
      if (is_data_pos(pos)) begin
        for (int i = 0; i < PAR_W; i++)
          if (pos[i]) par[i] = par[i] ^ d[k];
        k++;
      end
    end
    return par;
  endfunction

endpackage

// File: rtl/ecc_scrub_ctrl_if.sv
// CPU request/response port of the ECC scrub controller.
interface ecc_scrub_ctrl_if
  import ecc_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/hamming_ecc_unit.sv
// 32/39 SECDED encoder plus checker/corrector, purely combinational.
module hamming_ecc_unit
  import ecc_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] data_in,
  output logic [CODE_W-1:0] code_out,
  input  logic [CODE_W-1:0] code_in,
  output logic [DATA_W-1:0] data_out,
  output logic [PAR_W-1:0]  syn,
  output logic              s_err,
  output logic              d_err
);

  logic [PAR_W-1:0] enc_par;
  logic             odd;

  assign enc_par  = calc_par(data_in);
  // Overall parity makes the XOR of all 39 bits zero.
  assign code_out = {^{enc_par, data_in}, enc_par, data_in};

  assign syn   = calc_par(code_in[DATA_W-1:0]) ^ code_in[37:32];
  assign odd   = ^code_in;
  // A syndrome past position 38 with odd parity is a multi-bit error.
  assign s_err = odd && (syn != '0) && (syn <= 6'd38);
  // syn==0 with odd parity means only pG flipped: reported as neither.
  assign d_err = (syn != '0) && !s_err;

  // Flip the data bit the syndrome points at; check-bit hits leave data alone.
  always_comb begin
    int k;
    data_out = code_in[DATA_W-1:0];
    k = 0;
    for (int p = 3; p <= 38; p++) begin
      if (is_data_pos(6'(p))) begin
        if (s_err && (syn == 6'(p))) data_out[k] = ~data_out[k];
        k++;
      end
    end
  end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Sequencer between a CPU port and a SECDED-protected single-port memory,
// with a background scrubber that repairs single-bit errors.
module ecc_scrub_ctrl
  import ecc_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int SCRUB_PERIOD = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  ecc_scrub_ctrl_if.slave   cpu,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CODE_W-1:0] mem_wdata,
  input  logic [CODE_W-1:0] mem_rdata,
  input  logic              scrub_en,
  input  logic              ue_clr,
  output logic [15:0]       ce_count,
  output logic              ue_flag,
  output logic [ADDR_W-1:0] ue_addr
);

  localparam int TMR_W = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;

  state_e            state_q, state_d;
  src_e              tag_q, tag_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] corr_q, corr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic [15:0]       ce_q, ce_d;
  logic              ue_flag_q, ue_flag_d;
  logic [ADDR_W-1:0] ue_addr_q, ue_addr_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              pend_q, pend_d;

  logic [DATA_W-1:0] enc_data, dec_data;
  logic [CODE_W-1:0] enc_code;
  logic [PAR_W-1:0]  dec_syn;
  logic              dec_s_err, dec_d_err;
  logic              chk_corr, chk_ue;
  logic              tmr_fire, scrub_launch, ue_set;

  // Encoder sees write data in WR and the corrected word in WB.
  assign enc_data = (state_q == ST_WB) ? corr_q : wdata_q;

  hamming_ecc_unit u_ecc (
    .data_in  (enc_data),
    .code_out (enc_code),
    .code_in  (mem_rdata),
    .data_out (dec_data),
    .syn      (dec_syn),
    .s_err    (dec_s_err),
    .d_err    (dec_d_err)
  );

  assign chk_corr = dec_s_err;
  assign chk_ue   = dec_d_err && (dec_syn != '0);

  assign cpu.req_ready = (state_q == ST_IDLE);
  assign cpu.rsp_valid = rsp_valid_q;
  assign cpu.rsp_rdata = rsp_rdata_q;
  assign cpu.rsp_err   = rsp_err_q;

  assign mem_en    = (state_q == ST_WR) || (state_q == ST_RD) || (state_q == ST_WB);
  assign mem_we    = (state_q == ST_WR) || (state_q == ST_WB);
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_we ? enc_code : '0;

  assign ce_count = ce_q;
  assign ue_flag  = ue_flag_q;
  assign ue_addr  = ue_addr_q;

  // Next-state: FSM, response, scrub timer/pointer, error logging.
  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    corr_d       = corr_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = '0;
    rsp_err_d    = RSP_CLEAN;
    ce_d         = ce_q;
    ue_flag_d    = ue_flag_q;
    ue_addr_d    = ue_addr_q;
    ptr_d        = ptr_q;
    tmr_d        = tmr_q;
    tmr_fire     = 1'b0;
    scrub_launch = 1'b0;
    ue_set       = 1'b0;

    if (scrub_en) begin
      if (tmr_q == TMR_W'(SCRUB_PERIOD - 1)) begin
        tmr_d    = '0;
        tmr_fire = 1'b1;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        // CPU always wins; a pending scrub waits for an idle CPU cycle.
        if (cpu.req_valid) begin
          tag_d   = SRC_CPU;
          addr_d  = cpu.req_addr;
          wdata_d = cpu.req_wdata;
          state_d = cpu.req_we ? ST_WR : ST_RD;
        end else if (pend_q) begin
          tag_d        = SRC_SCRUB;
          addr_d       = ptr_q;
          state_d      = ST_RD;
          scrub_launch = 1'b1;
        end
      end
      ST_WR: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_RD: state_d = ST_CHK;
      ST_CHK: begin
        corr_d = dec_data;
        if (tag_q == SRC_CPU) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = dec_data;
          rsp_err_d   = chk_corr ? RSP_CORR : (chk_ue ? RSP_UNCORR : RSP_CLEAN);
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
        if (chk_corr) begin
          if (ce_q != 16'hFFFF) ce_d = ce_q + 16'd1;
          state_d = ST_WB;
        end else begin
          state_d = ST_IDLE;
        end
        ue_set = chk_ue;
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A new error beats a simultaneous clear and becomes the first logged one.
    if (ue_set) begin
      ue_flag_d = 1'b1;
      if (!ue_flag_q || ue_clr) ue_addr_d = addr_q;
    end else if (ue_clr) begin
      ue_flag_d = 1'b0;
      ue_addr_d = '0;
    end
  end

  assign pend_d = tmr_fire || (pend_q && !scrub_launch);

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tag_q       <= SRC_CPU;
      addr_q      <= '0;
      wdata_q     <= '0;
      corr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= RSP_CLEAN;
      ce_q        <= '0;
      ue_flag_q   <= 1'b0;
      ue_addr_q   <= '0;
      ptr_q       <= '0;
      tmr_q       <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      corr_q      <= corr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      ce_q        <= ce_d;
      ue_flag_q   <= ue_flag_d;
      ue_addr_q   <= ue_addr_d;
      ptr_q       <= ptr_d;
      tmr_q       <= tmr_d;
      pend_q      <= pend_d;
    end
  end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl with a behavioural 39-bit memory.
module tb_ecc_scrub_ctrl;

  localparam int AW = 4;
  localparam int SP = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [38:0]   mem_wdata;
  logic [38:0]   mem_rdata;
  logic          scrub_en, ue_clr;
  logic [15:0]   ce_count;
  logic          ue_flag;
  logic [AW-1:0] ue_addr;

  ecc_scrub_ctrl_if #(.ADDR_W(AW)) cpu_if ();

  ecc_scrub_ctrl #(.ADDR_W(AW), .SCRUB_PERIOD(SP)) dut (
    .clk(clk), .rst_n(rst_n), .cpu(cpu_if),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .scrub_en(scrub_en), .ue_clr(ue_clr),
    .ce_count(ce_count), .ue_flag(ue_flag), .ue_addr(ue_addr)
  );

  always #5 clk = ~clk;

  // Memory model plus a backdoor bit-flip port.
  bit [38:0]     mem_q [16];
  logic          bd_en;
  logic [AW-1:0] bd_addr;
  logic [38:0]   bd_mask;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_q[mem_addr] <= mem_wdata;
      else        mem_rdata       <= mem_q[mem_addr];
    end
    if (bd_en) mem_q[bd_addr] <= mem_q[bd_addr] ^ bd_mask;
  end

  int total = 0;
  int bad   = 0;

  // Reference SECDED encoder built from Hamming positions 1..38.
  function automatic logic [38:0] m_enc(input logic [31:0] d);
    logic [38:0] h;
    logic [5:0]  p;
    logic [38:0] cw;
    int k;
    h = '0;
    k = 0;
    for (int pos = 1; pos <= 38; pos++)
      if (pos != 1 && pos != 2 && pos != 4 && pos != 8 && pos != 16 && pos != 32) begin
        h[pos] = d[k];
        k++;
      end
    for (int i = 0; i < 6; i++) begin
      p[i] = 1'b0;
      for (int pos = 1; pos <= 38; pos++)
        if (((pos >> i) & 1) == 1) p[i] = p[i] ^ h[pos];
    end
    cw = {1'b0, p, d};
    cw[38] = ^cw[37:0];
    return cw;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Results captured by the transaction tasks.
  logic          w_en, w_we, w_v;
  logic [38:0]   w_wdata;
  logic [31:0]   w_rdata;
  logic [1:0]    w_err;
  logic          r_early, r_v, r_rdy, r_wen, r_wwe;
  logic [31:0]   r_data;
  logic [1:0]    r_err;
  logic [AW-1:0] r_waddr;
  logic [38:0]   r_wdata;

  task do_write(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    cpu_if.req_valid = 1'b1; cpu_if.req_we = 1'b1;
    cpu_if.req_addr  = a;    cpu_if.req_wdata = d;
    @(negedge clk);
    cpu_if.req_valid = 1'b0;
    w_en = mem_en; w_we = mem_we; w_wdata = mem_wdata;
    @(negedge clk);
    w_v = cpu_if.rsp_valid; w_rdata = cpu_if.rsp_rdata; w_err = cpu_if.rsp_err;
  endtask

  // Returns at the negedge of cycle T+3 (response / writeback cycle).
  task do_read(input logic [AW-1:0] a);
    @(negedge clk);
    cpu_if.req_valid = 1'b1; cpu_if.req_we = 1'b0; cpu_if.req_addr = a;
    @(negedge clk);
    cpu_if.req_valid = 1'b0;
    @(negedge clk);
    r_early = cpu_if.rsp_valid;
    @(negedge clk);
    r_v = cpu_if.rsp_valid; r_data = cpu_if.rsp_rdata; r_err = cpu_if.rsp_err;
    r_wen = mem_en; r_wwe = mem_we; r_waddr = mem_addr; r_wdata = mem_wdata;
    r_rdy = cpu_if.req_ready;
  endtask

  task flip(input logic [AW-1:0] a, input logic [38:0] m);
    @(negedge clk);
    bd_en = 1'b1; bd_addr = a; bd_mask = m;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  logic [AW-1:0] rdq[$];
  int            wcnt, fix_cyc, nxt_ptr;
  logic [AW-1:0] waddr, n0addr;
  logic          found;

  initial begin
    rst_n = 1'b0; scrub_en = 1'b0; ue_clr = 1'b0;
    bd_en = 1'b0; bd_addr = '0; bd_mask = '0;
    cpu_if.req_valid = 1'b0; cpu_if.req_we = 1'b0;
    cpu_if.req_addr = '0; cpu_if.req_wdata = '0;
    repeat (3) @(negedge clk);

    chk("rst_ready",   64'(cpu_if.req_ready), 1);
    chk("rst_rsp_v",   64'(cpu_if.rsp_valid), 0);
    chk("rst_mem_en",  64'({mem_en, mem_we}), 0);
    chk("rst_mem_adr", 64'(mem_addr), 0);
    chk("rst_mem_wd",  64'(mem_wdata), 0);
    chk("rst_ce",      64'(ce_count), 0);
    chk("rst_ue",      64'({ue_flag, ue_addr}), 0);
    rst_n = 1'b1;

    // Clean write then read.
    do_write(4'd5, 32'hDEADBEEF);
    chk("wr_strobe", 64'({w_en, w_we}), 64'b11);
    chk("wr_code",   64'(w_wdata), 64'(m_enc(32'hDEADBEEF)));
    chk("wr_rsp",    64'({w_v, w_err, w_rdata}), 64'({1'b1, 2'b00, 32'h0}));
    do_read(4'd5);
    chk("rd_early",  64'(r_early), 0);
    chk("rd_rsp",    64'({r_v, r_err, r_data}), 64'({1'b1, 2'b00, 32'hDEADBEEF}));
    chk("rd_no_wb",  64'(r_wen), 0);
    chk("rd_ce",     64'(ce_count), 0);

    // Single data-bit error: corrected, written back.
    flip(4'd5, 39'd1 << 7);
    do_read(4'd5);
    chk("ce_rsp",    64'({r_v, r_err, r_data}), 64'({1'b1, 2'b01, 32'hDEADBEEF}));
    chk("ce_wb",     64'({r_wen, r_wwe, r_waddr}), 64'({2'b11, 4'd5}));
    chk("ce_wbdata", 64'(r_wdata), 64'(m_enc(32'hDEADBEEF)));
    chk("ce_busy",   64'(r_rdy), 0);
    chk("ce_cnt1",   64'(ce_count), 1);
    @(negedge clk);
    chk("ce_mem",    64'(mem_q[5]), 64'(m_enc(32'hDEADBEEF)));

    // Check-bit-only error: data unchanged, still counted and repaired.
    flip(4'd5, 39'd1 << 33);
    do_read(4'd5);
    chk("cb_rsp",    64'({r_err, r_data}), 64'({2'b01, 32'hDEADBEEF}));
    chk("cb_wbdata", 64'({r_wen, r_wdata}), 64'({1'b1, m_enc(32'hDEADBEEF)}));
    chk("cb_cnt2",   64'(ce_count), 2);

    // Overall-parity-only error: clean, not counted, no writeback.
    flip(4'd5, 39'd1 << 38);
    do_read(4'd5);
    chk("pg_rsp",    64'({r_err, r_data}), 64'({2'b00, 32'hDEADBEEF}));
    chk("pg_no_wb",  64'(r_wen), 0);
    chk("pg_cnt",    64'(ce_count), 2);

    // Double error at 9, then a second one at 2.
    do_write(4'd9, 32'hCAFEF00D);
    flip(4'd9, (39'd1 << 3) | (39'd1 << 20));
    do_read(4'd9);
    chk("ue_rsp",    64'({r_v, r_err, r_data}), 64'({1'b1, 2'b10, 32'hCAEEF005}));
    chk("ue_no_wb",  64'(r_wen), 0);
    chk("ue_log",    64'({ue_flag, ue_addr}), 64'({1'b1, 4'd9}));
    chk("ue_cnt",    64'(ce_count), 2);
    do_write(4'd2, 32'h0F0F0F0F);
    flip(4'd2, 39'd3);
    do_read(4'd2);
    chk("ue2_rsp",   64'({r_err, r_data}), 64'({2'b10, 32'h0F0F0F0C}));
    chk("ue2_keep",  64'({ue_flag, ue_addr}), 64'({1'b1, 4'd9}));
    @(negedge clk); ue_clr = 1'b1;
    @(negedge clk); ue_clr = 1'b0;
    chk("ue_clr",    64'({ue_flag, ue_addr}), 0);

    // Restore clean contents before scrubbing.
    do_write(4'd9, 32'h0);
    do_write(4'd2, 32'h0F0F0F0F);
    do_write(4'd5, 32'hDEADBEEF);
    do_write(4'd1, 32'h12345678);

    // Scrubber repairs a single flip at addr 2 and walks/wraps the array.
    flip(4'd2, 39'd1 << 12);
    @(negedge clk); scrub_en = 1'b1;
    wcnt = 0; fix_cyc = -1; waddr = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (mem_en && !mem_we) rdq.push_back(mem_addr);
      if (mem_en && mem_we) begin wcnt++; waddr = mem_addr; end
      if (fix_cyc < 0 && mem_q[2] === m_enc(32'h0F0F0F0F)) fix_cyc = cyc;
    end
    chk("sc_fixed",  64'(fix_cyc >= 0 && fix_cyc <= 64), 1);
    chk("sc_ce",     64'(ce_count), 3);
    chk("sc_wb",     64'({wcnt[7:0], waddr}), 64'({8'd1, 4'd2}));
    chk("sc_nreads", 64'(rdq.size() >= 17), 1);
    chk("sc_first",  64'((rdq.size() > 0) ? rdq[0] : 4'hF), 0);
    chk("sc_last",   64'((rdq.size() > 15) ? rdq[15] : 4'h0), 15);
    chk("sc_wrap",   64'((rdq.size() > 16) ? rdq[16] : 4'hF), 0);
    chk("sc_ue",     64'(ue_flag), 0);

    // CPU read raised in the cycle the next scrub becomes pending.
    found = 1'b0; n0addr = '0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mem_en && !mem_we) begin found = 1'b1; n0addr = mem_addr; end
    end
    chk("pr_found",  64'(found), 1);
    chk("pr_ptr",    64'(n0addr), 64'(rdq.size() % 16));
    nxt_ptr = (rdq.size() + 1) % 16;
    repeat (15) @(negedge clk);
    cpu_if.req_valid = 1'b1; cpu_if.req_we = 1'b0; cpu_if.req_addr = 4'd1;
    chk("pr_ready",  64'(cpu_if.req_ready), 1);
    @(negedge clk);
    cpu_if.req_valid = 1'b0;
    chk("pr_cpu_rd", 64'({mem_en, mem_we, mem_addr}), 64'({2'b10, 4'd1}));
    @(negedge clk);
    @(negedge clk);
    chk("pr_rsp",    64'({cpu_if.rsp_valid, cpu_if.rsp_rdata}), 64'({1'b1, 32'h12345678}));
    @(negedge clk);
    chk("pr_scrub",  64'({mem_en, mem_we, mem_addr}), 64'({2'b10, 4'(nxt_ptr)}));
    scrub_en = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while a writeback is on the bus.
    flip(4'd5, 39'd1);
    do_read(4'd5);
    chk("rw_wb",     64'({r_wen, r_wwe, r_err}), 64'({2'b11, 2'b01}));
    rst_n = 1'b0;
    @(negedge clk);
    chk("rw_idle",   64'(cpu_if.req_ready), 1);
    chk("rw_outs",   64'({cpu_if.rsp_valid, cpu_if.rsp_err, mem_en, mem_we, mem_addr}), 0);
    chk("rw_wdata",  64'({mem_wdata, cpu_if.rsp_rdata}), 0);
    chk("rw_cnt",    64'({ce_count, ue_flag, ue_addr}), 0);
    rst_n = 1'b1; scrub_en = 1'b1;
    found = 1'b0; n0addr = 4'hF;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mem_en && !mem_we) begin found = 1'b1; n0addr = mem_addr; end
    end
    chk("rw_ptr0",   64'({found, n0addr}), 64'({1'b1, 4'd0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
